dsp_simd_addsub_sched: RTL
==========================

// Module: dsp_simd_addsub_sched
// PURPOSE
//  Shares one DSP48E2 configured as a SIMD add/sub unit among N_REQ requesters.
//  - Up to LANES same-op requests are packed into 12-bit lanes each cycle.
//  - Drives the DSP A/B/C/ALUMODE ports.
//  - Tracks lane ownership through the DSP pipeline and routes each lane result back to its requester.
//  Sits between client datapaths and a DSP48E2 instance with USE_SIMD="FOUR12", USE_MULT="NONE", OPMODE=9'b000110011.
// PARAMETERS
//  N_REQ    4   number of requesters (2..8)
//  LANES    3   SIMD lanes used per issue (1..4)
//  WIDTH   12   operand/result width per request (1..12)
//  DSP_LAT  1   DSP register stages from A/B/C/ALUMODE to P (0..2; 1 = PREG only)
// PORTS
//  clock        in   1             rising-edge clock
//  reset        in   1             asynchronous, active-low reset
//  req_valid    in   N_REQ         request valid per requester
//  req_ready    out  N_REQ         grant; transfer when valid&&ready at clock edge
//  req_op       in   N_REQ         per requester: 0=add (a+b), 1=sub (a-b)
//  req_a        in   N_REQ*WIDTH   operand a, requester i at [i*WIDTH +: WIDTH]
//  req_b        in   N_REQ*WIDTH   operand b, same packing
//  rsp_valid    out  N_REQ         one-cycle result strobe per requester
//  rsp_y        out  N_REQ*WIDTH   result, valid only while rsp_valid[i]
//  dsp_alumode  out  4             0000=add, 0011=sub (Z-(X+Y))
//  dsp_a        out  30            A port = packed b[47:18]
//  dsp_b        out  18            B port = packed b[17:0]
//  dsp_c        out  48            C port = packed a
//  dsp_p        in   48            DSP P output
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - dsp_a, dsp_b, dsp_c and rsp_y = 0; dsp_alumode = 0000; rsp_valid = 0; req_ready = 0.
//   - RR pointer = 0; all in-flight tags invalid.
//   - Asserting reset mid-operation drops in-flight ops: no rsp_valid for them after release.
//  Grant (combinational from req_valid, req_op, ptr):
//   - Scan i = ptr, ptr+1, ... mod N_REQ. The first valid requester fixes this cycle's op.
//   - Grant valid requesters whose req_op equals that op, in scan order, up to LANES grants.
//   - The k-th grant takes lane k. Non-matching-op requesters are skipped, not blocking.
//   - No valid requester: no grant, ptr unchanged.
//   - Otherwise ptr <= (last granted index + 1) mod N_REQ.
//  Issue register (edge where grant occurs):
//   - Lane k bits [12k +: 12]: C gets sign-extended a; {A,B} gets sign-extended b.
//   - Unused lanes and bits above 12*LANES = 0. dsp_alumode = op.
//   - If there is no grant, dsp_* hold their values and the issued tag is invalid.
//  Tag pipeline: per lane {valid, requester index}, depth 1+DSP_LAT, shifts every cycle. No stalls; the DSP is fully pipelined.
//  Response register:
//   - For each valid tag lane k at the pipeline tail, rsp_valid[idx] <= 1 and rsp_y[idx] <= dsp_p[12k +: WIDTH].
//   - Latency: handshake edge T -> rsp_valid high in the cycle after edge T+1+DSP_LAT (2 cycles for DSP_LAT=1).
//   - A requester can own at most one lane per issue, so there are no rsp collisions.
//  Arithmetic: lane-independent modulo 2^12 (no carry across lanes), truncated to WIDTH. Equivalent to (a±b) mod 2^WIDTH.
//  A requester may hold req_valid across cycles; each accepted edge is a separate op.
// TESTING
//  1 N_REQ=4, LANES=3, DSP_LAT=1, req0 sub a=5 b=3 -> ready0 at once; dsp_alumode=0011; rsp_valid[0] 2 cycles later, y=2.
//  2 req0..3 all add (a=i, b=10), ptr=0 -> edge1 grants 0,1,2 on lanes 0..2; edge2 grants 3 on lane 0; y=10,11,12,13.
//  3 req0 sub, req1 add, req2 sub, ptr=0 -> cycle1 grants {0,2} alumode 0011; cycle2 grants {1} alumode 0000; ptr ends 2.
//  4 Lane isolation: lane0 0xFFF+0x001 and lane1 0x800-0x001 in one issue -> y=0x000 and 0x7FF, no cross-lane carry.
//  5 All 4 requesters continuously valid add -> grant sets {0,1,2},{3,0,1},{2,3,0}; each requester gets 3 grants in 4 cycles.
//  6 Reset asserted 1 cycle after two issues -> outputs 0 immediately; after release no rsp_valid; next grant starts at req0.

Source files
------------

// File: rtl/dsp_simd_addsub_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dsp_simd_addsub_sched : packs same-op add/sub requests into DSP48E2 lanes |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dsp_simd_addsub_sched #(
  parameter int N_REQ   = 4,
  parameter int LANES   = 3,
  parameter int WIDTH   = 12,
  parameter int DSP_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ-1:0]       req_op,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [N_REQ*WIDTH-1:0] rsp_y,
  output logic [3:0]             dsp_alumode,
  output logic [29:0]            dsp_a,
  output logic [17:0]            dsp_b,
  output logic [47:0]            dsp_c,
  input  logic [47:0]            dsp_p
);

  localparam int              IDXW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int              DEPTH   = 1 + DSP_LAT;
  localparam logic [IDXW:0]   NREQ_W  = (IDXW+1)'(N_REQ);
  localparam logic [IDXW:0]   LAST_W  = (IDXW+1)'(N_REQ - 1);
  localparam logic [3:0]      ALU_ADD = 4'b0000;
  localparam logic [3:0]      ALU_SUB = 4'b0011;

  logic [IDXW-1:0]       ptr;
  logic [IDXW-1:0]       ptr_nxt;
  logic                  found;
  logic                  op;
  logic [IDXW-1:0]       last_idx;
  logic [N_REQ-1:0]      grant;
  logic [LANES-1:0]      lane_vld;
  logic [LANES*IDXW-1:0] lane_idx;

  // Round-robin scan: first valid requester fixes the op, others of that op fill lanes.
  always_comb begin
    logic [IDXW:0]   sum;
    logic [IDXW-1:0] idx;
    int              cnt;
    found    = 1'b0;
    op       = 1'b0;
    last_idx = ptr;
    grant    = '0;
    lane_vld = '0;
    lane_idx = '0;
    cnt      = 0;
    sum      = '0;
    idx      = '0;
    for (int j = 0; j < N_REQ; j++) begin
      sum = {1'b0, ptr} + (IDXW+1)'(j);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      idx = sum[IDXW-1:0];
      if (req_valid[idx]) begin
        if (!found) begin
          found = 1'b1;
          op    = req_op[idx];
        end
        if ((req_op[idx] == op) && (cnt < LANES)) begin
          grant[idx] = 1'b1;
          last_idx   = idx;
          for (int k = 0; k < LANES; k++) begin
            if (k == cnt) begin
              lane_vld[k]               = 1'b1;
              lane_idx[k*IDXW +: IDXW]  = idx;
            end
          end
          cnt = cnt + 1;
        end
      end
    end
  end

  assign req_ready = grant & {N_REQ{rst_n}};

  always_comb begin
    ptr_nxt = ptr;
    if (found) begin
      if ({1'b0, last_idx} == LAST_W) ptr_nxt = '0;
      else                            ptr_nxt = last_idx + 1'b1;
    end
  end

  function automatic logic [11:0] sext12(input logic [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] s;
    s = v;
    return 12'(s);
  endfunction

  logic [47:0] c_nxt;
  logic [47:0] ab_nxt;
  logic [47:0] ab_q;

  always_comb begin
    c_nxt  = '0;
    ab_nxt = '0;
    for (int k = 0; k < LANES; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (lane_vld[k] && (lane_idx[k*IDXW +: IDXW] == IDXW'(i))) begin
          c_nxt[12*k +: 12]  = sext12(req_a[i*WIDTH +: WIDTH]);
          ab_nxt[12*k +: 12] = sext12(req_b[i*WIDTH +: WIDTH]);
        end
      end
    end
  end

  assign dsp_a = ab_q[47:18];
  assign dsp_b = ab_q[17:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      ab_q        <= '0;
      dsp_c       <= '0;
      dsp_alumode <= ALU_ADD;
    end else begin
      ptr <= ptr_nxt;
      if (found) begin
        ab_q        <= ab_nxt;
        dsp_c       <= c_nxt;
        dsp_alumode <= op ? ALU_SUB : ALU_ADD;
      end
    end
  end

  // Lane ownership follows the operands through the DSP register stages.
  logic [LANES-1:0]      tag_vld [DEPTH];
  logic [LANES*IDXW-1:0] tag_idx [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < DEPTH; s++) begin
        tag_vld[s] <= '0;
        tag_idx[s] <= '0;
      end
    end else begin
      tag_vld[0] <= lane_vld;
      tag_idx[0] <= lane_idx;
      for (int s = 1; s < DEPTH; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_idx[s] <= tag_idx[s-1];
      end
    end
  end

  logic [N_REQ-1:0]       rsp_valid_nxt;
  logic [N_REQ*WIDTH-1:0] rsp_y_nxt;

  always_comb begin
    rsp_valid_nxt = '0;
    rsp_y_nxt     = rsp_y;
    for (int i = 0; i < N_REQ; i++) begin
      for (int k = 0; k < LANES; k++) begin
        if (tag_vld[DEPTH-1][k] && (tag_idx[DEPTH-1][k*IDXW +: IDXW] == IDXW'(i))) begin
          rsp_valid_nxt[i]              = 1'b1;
          rsp_y_nxt[i*WIDTH +: WIDTH]   = dsp_p[12*k +: WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_y     <= '0;
    end else begin
      rsp_valid <= rsp_valid_nxt;
      rsp_y     <= rsp_y_nxt;
    end
  end

  logic unused_p;
  assign unused_p = ^dsp_p;

endmodule
`default_nettype wire
